// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage: OP, OP-IMM and LUI into ALU operand fields,
// 32x32 register file with write-through, one-entry output register toward execute.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic        illegal
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111
    } opcode_e;

    logic [31:0] regs [32];

    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic        accept;

    logic        dec_legal;
    logic [31:0] dec_in1, dec_in2;
    logic [2:0]  dec_funct3;
    logic        dec_funct7;

    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];

    assign if_ready = !rst && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // x0 reads as zero; a same-cycle writeback to the source register is forwarded.
    assign op1 = (rs1 == 5'd0) ? 32'd0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    assign op2 = (rs2 == 5'd0) ? 32'd0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_legal  = 1'b0;
        dec_in1    = op1;
        dec_in2    = op2;
        dec_funct3 = funct3;
        dec_funct7 = 1'b0;
        case (if_instr[6:0])
            OPC_OP: begin
                dec_legal  = 1'b1;
                dec_funct7 = if_instr[30];
            end
            OPC_OP_IMM: begin
                dec_legal  = 1'b1;
                dec_in2    = {{20{if_instr[31]}}, if_instr[31:20]};
                // Only SRAI carries the modifier; ADDI with imm[10] set must not turn into SUB.
                dec_funct7 = (funct3 == 3'b101) ? if_instr[30] : 1'b0;
            end
            OPC_LUI: begin
                dec_legal  = 1'b1;
                dec_in1    = 32'd0;
                dec_in2    = {if_instr[31:12], 12'd0};
                dec_funct3 = 3'b000;
            end
            default: ;
        endcase
    end

    // NOTE: the register file is reset on purpose (architectural state must start at zero),
    // so it is built from flops rather than an unreset RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_in1    <= '0;
            ex_in2    <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= 1'b0;
            ex_rd     <= '0;
            ex_rd_we  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept && dec_legal) begin
                ex_valid  <= 1'b1;
                ex_in1    <= dec_in1;
                ex_in2    <= dec_in2;
                ex_funct3 <= dec_funct3;
                ex_funct7 <= dec_funct7;
                ex_rd     <= rd;
                ex_rd_we  <= (rd != 5'd0);
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, bypass, x0, backpressure,
// streaming, illegal opcode and reset-while-full.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [2:0]  ex_funct3;
    logic        ex_funct7;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // {valid, in1, in2, funct3, funct7, rd, rd_we}
    logic [74:0] got;
    assign got = {ex_valid, ex_in1, ex_in2, ex_funct3, ex_funct7, ex_rd, ex_rd_we};

    id_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr);
        if_valid = 1'b1; if_instr = instr;
        step();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if (got !== 75'd0) begin
            errors++; $display("FAIL reset_fields: got %h want %h", got, 75'd0);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal: got %b want 0", illegal);
        end
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL reset_if_ready: got %b want 0", if_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_if_ready: got %b want 1", if_ready);
        end
    endtask

    task automatic test_sub();
        wb_write(5'd5, 32'h0000_0AC3);
        wb_write(5'd6, 32'h0000_011F);
        issue(32'h4062_83B3);
        checks++;
        if (got !== {1'b1, 32'h0000_0AC3, 32'h0000_011F, 3'd0, 1'b1, 5'd7, 1'b1}) begin
            errors++; $display("FAIL sub: got %h", got);
        end
        // SRA x9,x5,x6
        issue(32'h4062_D4B3);
        checks++;
        if (got !== {1'b1, 32'h0000_0AC3, 32'h0000_011F, 3'd5, 1'b1, 5'd9, 1'b1}) begin
            errors++; $display("FAIL sra: got %h", got);
        end
    endtask

    task automatic test_imm();
        wb_write(5'd5, 32'hA100_0015);
        issue(32'h4022_D413);
        checks++;
        if (got !== {1'b1, 32'hA100_0015, 32'h0000_0402, 3'd5, 1'b1, 5'd8, 1'b1}) begin
            errors++; $display("FAIL srai: got %h", got);
        end
        issue(32'hFFF0_0093);
        checks++;
        if (got !== {1'b1, 32'h0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd1, 1'b1}) begin
            errors++; $display("FAIL addi_m1: got %h", got);
        end
        issue(32'hA100_01B7);
        checks++;
        if (got !== {1'b1, 32'h0, 32'hA100_0000, 3'd0, 1'b0, 5'd3, 1'b1}) begin
            errors++; $display("FAIL lui: got %h", got);
        end
    endtask

    task automatic test_bypass_x0();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hC000_0027;
        issue(32'h0062_83B3);
        wb_en = 1'b0;
        checks++;
        if (got !== {1'b1, 32'hC000_0027, 32'h0000_011F, 3'd0, 1'b0, 5'd7, 1'b1}) begin
            errors++; $display("FAIL bypass: got %h", got);
        end
        // ADD x0,x5,x6: x5 now from the register file, rd_we must be 0
        issue(32'h0062_8033);
        checks++;
        if (got !== {1'b1, 32'hC000_0027, 32'h0000_011F, 3'd0, 1'b0, 5'd0, 1'b0}) begin
            errors++; $display("FAIL rd_x0: got %h", got);
        end
        wb_write(5'd0, 32'hFFFF_FFFF);
        issue(32'h0000_03B3);
        checks++;
        if (got !== {1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd7, 1'b1}) begin
            errors++; $display("FAIL x0_read: got %h", got);
        end
        // same-cycle write to x0 must not forward
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        issue(32'h0000_03B3);
        wb_en = 1'b0;
        checks++;
        if (got !== {1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd7, 1'b1}) begin
            errors++; $display("FAIL x0_bypass: got %h", got);
        end
    endtask

    task automatic test_backpressure();
        logic [74:0] exp_a, exp_b;
        exp_a = {1'b1, 32'hC000_0027, 32'h0000_011F, 3'd0, 1'b0, 5'd7, 1'b1};
        exp_b = {1'b1, 32'h0, 32'hA100_0000, 3'd0, 1'b0, 5'd3, 1'b1};
        step();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = 32'h0062_83B3;
        step();
        if_instr = 32'hA100_01B7;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (if_ready !== 1'b0) begin
                errors++; $display("FAIL bp_if_ready cycle %0d: got %b want 0", c, if_ready);
            end
            checks++;
            if (got !== exp_a) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %h want %h", c, got, exp_a);
            end
            step();
        end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", if_ready);
        end
        step();
        if_valid = 1'b0;
        checks++;
        if (got !== exp_b) begin
            errors++; $display("FAIL bp_second: got %h want %h", got, exp_b);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: got %b want 0", ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] imm;
        logic [4:0]  r;
        for (int i = 0; i < 7; i++) begin
            imm = 12'(i * 3 + 1);
            r   = 5'(i + 1);
            if_valid = 1'b1;
            if_instr = {imm, 5'd0, 3'd0, r, 7'b0010011};
            #1;
            checks++;
            if (if_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready %0d: got %b want 1", i, if_ready);
            end
            step();
            checks++;
            if (got !== {1'b1, 32'h0, 20'd0, imm, 3'd0, 1'b0, r, 1'b1}) begin
                errors++; $display("FAIL b2b_entry %0d: got %h", i, got);
            end
        end
        if_valid = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b want 0", ex_valid);
        end
    endtask

    task automatic test_illegal();
        issue(32'h0000_0000);
        checks++;
        if (illegal !== 1'b1 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse: illegal %b ex_valid %b want 1 0", illegal, ex_valid);
        end
        step();
        checks++;
        if (illegal !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_end: illegal %b ex_valid %b want 0 0", illegal, ex_valid);
        end
    endtask

    task automatic test_reset_full();
        ex_ready = 1'b0;
        issue(32'h0062_83B3);
        checks++;
        if (ex_valid !== 1'b1) begin
            errors++; $display("FAIL rf_full: got %b want 1", ex_valid);
        end
        rst = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
        step();
        checks++;
        if (got !== 75'd0 || if_ready !== 1'b0) begin
            errors++; $display("FAIL rf_cleared: got %h if_ready %b want 0 0", got, if_ready);
        end
        rst = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
        issue(32'h0062_83B3);
        checks++;
        if (got !== {1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd7, 1'b1}) begin
            errors++; $display("FAIL rf_regs_zero: got %h", got);
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        test_reset();
        test_sub();
        test_imm();
        test_bypass_x0();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
